// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and the buffered writeback entry type
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular buffer of long-latency results with per-entry visibility
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  wb_entry_t        push_data_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output wb_entry_t        entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);
    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign entries_o = mem_q;

    always_comb begin
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        int off;
        off     = 0;
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = (i >= int'(rd_ptr_q)) ? i - int'(rd_ptr_q) : i + DEPTH - int'(rd_ptr_q);
            valid_o[i] = (off < int'(count_q));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges pipe and long-latency writebacks onto one register-file port
// Optional stall statistics counter enabled with WB_STATS_EN.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    input  logic                  ls_valid,
    output logic                  ls_ready,
    input  logic [REG_ADDR_W-1:0] ls_rd,
    input  logic [XLEN-1:0]       ls_data,
    output logic                  write_enable,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       rd_din,
    output logic [NUM_REGS-1:0]   pending_mask
`ifdef WB_STATS_EN
    ,
    output logic [31:0]           ls_stall_cnt
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  we_q, we_d;
    logic                  from_ls_q, from_ls_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       din_q, din_d;

    logic                  pipe_wr, push, pop;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    wb_entry_t             fifo_head;
    wb_entry_t             fifo_entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_valid;
    wb_entry_t             ls_entry;

    // A pipe write to x0 is a no-op, so it must not steal the port from the FIFO.
    assign pipe_wr  = pipe_valid && (pipe_rd != '0);
    assign ls_ready = !fifo_full;
    assign push     = ls_valid && ls_ready && (ls_rd != '0);
    assign pop      = !fifo_empty && !pipe_wr;
    assign ls_entry = '{rd: ls_rd, data: ls_data};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (ls_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .entries_o   (fifo_entries),
        .valid_o     (fifo_valid)
    );

    always_comb begin
        we_d      = pipe_wr || pop;
        from_ls_d = pop;
        rd_d      = rd_q;
        din_d     = din_q;
        if (pipe_wr) begin
            rd_d  = pipe_rd;
            din_d = pipe_data;
        end else if (pop) begin
            rd_d  = fifo_head.rd;
            din_d = fifo_head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            from_ls_q <= 1'b0;
            rd_q      <= '0;
            din_q     <= '0;
        end else begin
            we_q      <= we_d;
            from_ls_q <= from_ls_d;
            rd_q      <= rd_d;
            din_q     <= din_d;
        end
    end

    assign write_enable = we_q;
    assign rd           = rd_q;
    assign rd_din       = din_q;

    // A result stays pending until the cycle its write is presented to the register file has passed.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid[i]) begin
                pending_mask[fifo_entries[i].rd] = 1'b1;
            end
        end
        if (we_q && from_ls_q) begin
            pending_mask[rd_q] = 1'b1;
        end
    end

`ifdef WB_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (ls_valid && !ls_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign ls_stall_cnt = stall_q;
`endif

    a_no_pipe_hazard: assert property (@(posedge clk) disable iff (reset)
        !(pipe_valid && (pipe_rd != '0) && pending_mask[pipe_rd]));

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= CNT_W'(FIFO_DEPTH));
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, ls_valid, ls_ready, write_enable;
    logic [4:0]  pipe_rd, ls_rd, rd;
    logic [31:0] pipe_data, ls_data, rd_din, pending_mask;
`ifdef WB_STATS_EN
    logic [31:0] ls_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    wb_entry_t exp_q [$];

    always #5 clk = ~clk;

    writeback_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_valid   (pipe_valid),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .ls_valid     (ls_valid),
        .ls_ready     (ls_ready),
        .ls_rd        (ls_rd),
        .ls_data      (ls_data),
        .write_enable (write_enable),
        .rd           (rd),
        .rd_din       (rd_din),
        .pending_mask (pending_mask)
`ifdef WB_STATS_EN
        ,
        .ls_stall_cnt (ls_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back('{rd: r, data: d});
    endtask

    // Monitor: every presented write must be the next one the scoreboard expects.
    always @(negedge clk) begin
        if (!reset && write_enable) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", {27'd0, rd, rd_din}, 64'd0);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                chk("wb_write", {27'd0, rd, rd_din}, {27'd0, e.rd, e.data});
            end
        end
    end

    logic [4:0] t6_rd [6];
    int acc;

    initial begin
        t6_rd = '{5'd27, 5'd28, 5'd29, 5'd30, 5'd31, 5'd1};
        reset = 1'b1;
        pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        ls_valid = 0;   ls_rd = 0;   ls_data = 0;
        #2;
        chk("rst_we", write_enable, 0);
        chk("rst_rd", rd, 0);
        chk("rst_din", rd_din, 0);
        chk("rst_pending", pending_mask, 0);
        chk("rst_ready", ls_ready, 1);
        @(posedge clk); #1 reset = 1'b0;

        // Single pipe write, one cycle latency
        pipe_valid = 1; pipe_rd = 5; pipe_data = 32'h1234;
        expect_wr(5, 32'h1234);
        step();
        pipe_valid = 0;
        @(negedge clk);
        chk("t1_we", write_enable, 1);
        chk("t1_rd", rd, 5);
        chk("t1_din", rd_din, 32'h1234);
        step();

        // Pipe and ls collide: pipe first, ls next, pending for two cycles
        ls_valid = 1; ls_rd = 7; ls_data = 32'hAA;
        pipe_valid = 1; pipe_rd = 3; pipe_data = 32'h33;
        chk("t2_ready", ls_ready, 1);
        expect_wr(3, 32'h33);
        expect_wr(7, 32'hAA);
        step();
        ls_valid = 0; pipe_valid = 0;
        @(negedge clk);
        chk("t2_pend_c1", pending_mask, 32'h80);
        chk("t2_rd_c1", rd, 3);
        step();
        @(negedge clk);
        chk("t2_pend_c2", pending_mask, 32'h80);
        chk("t2_rd_c2", rd, 7);
        step();
        @(negedge clk);
        chk("t2_pend_c3", pending_mask, 0);
        chk("t2_we_c3", write_enable, 0);
        chk("t2_hold_rd", rd, 7);
        chk("t2_hold_din", rd_din, 32'hAA);
        step();

        // Busy pipe back-pressures ls after two accepts, then drains in order
        expect_wr(20, 32'hB0); expect_wr(21, 32'hB1);
        expect_wr(22, 32'hB2); expect_wr(23, 32'hB3);
        expect_wr(10, 32'hA0); expect_wr(11, 32'hA1); expect_wr(12, 32'hA2);
        acc = 0;
        for (int c = 0; c < 7; c++) begin
            pipe_valid = (c < 4);
            pipe_rd    = 5'(20 + c);
            pipe_data  = 32'hB0 + 32'(c);
            ls_valid   = (acc < 3);
            ls_rd      = 5'(10 + acc);
            ls_data    = 32'hA0 + 32'(acc);
            if (c >= 2 && c <= 4) chk($sformatf("t3_ready_low_c%0d", c), ls_ready, 0);
            if (c == 5) chk("t3_ready_back", ls_ready, 1);
            if (c == 2) chk("t3_accepts_at_full", 64'(acc), 2);
            if (ls_valid && ls_ready) acc++;
            step();
        end
        pipe_valid = 0; ls_valid = 0;
        chk("t3_accepts", 64'(acc), 3);
        repeat (3) step();

        // x0 traffic is accepted and dropped
        ls_valid = 1; ls_rd = 0; ls_data = 32'hDEAD;
        pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hBEEF;
        chk("t4_ready", ls_ready, 1);
        step();
        ls_valid = 0; pipe_valid = 0;
        @(negedge clk);
        chk("t4_we", write_enable, 0);
        chk("t4_count", dut.u_fifo.count_o, 0);
        chk("t4_pending", pending_mask, 0);
        step();

        // Pipe write to x0 does not block the drain
        ls_valid = 1; ls_rd = 9; ls_data = 32'h99;
        expect_wr(9, 32'h99);
        step();
        ls_valid = 0;
        pipe_valid = 1; pipe_rd = 0; pipe_data = 32'h1;
        step();
        pipe_valid = 0;
        @(negedge clk);
        chk("t4_x0_drain_we", write_enable, 1);
        chk("t4_x0_drain_rd", rd, 9);
        step();

        // Reset with two buffered entries discards them
        ls_valid = 1; ls_rd = 14; ls_data = 32'hE14;
        pipe_valid = 1; pipe_rd = 24; pipe_data = 32'hC24;
        expect_wr(24, 32'hC24);
        step();
        ls_rd = 15; ls_data = 32'hE15;
        pipe_rd = 25; pipe_data = 32'hC25;
        expect_wr(25, 32'hC25);
        step();
        ls_valid = 0;
        pipe_rd = 26; pipe_data = 32'hC26;
        chk("t5_full", ls_ready, 0);
        expect_wr(26, 32'hC26);
        step();
        pipe_valid = 0;
        @(negedge clk);
        chk("t5_pend_pre", pending_mask, 32'h0000_C000);
        #1 reset = 1'b1;
        #1;
        chk("t5_we", write_enable, 0);
        chk("t5_rd", rd, 0);
        chk("t5_din", rd_din, 0);
        chk("t5_pending", pending_mask, 0);
        @(posedge clk); #1 reset = 1'b0;
        chk("t5_ready", ls_ready, 1);
        chk("t5_pend_post", pending_mask, 0);
        repeat (4) step();

        // Stalls on a full FIFO
        for (int c = 0; c < 6; c++) begin
            pipe_valid = 1;
            pipe_rd    = t6_rd[c];
            pipe_data  = 32'hD0 + 32'(c);
            expect_wr(t6_rd[c], 32'hD0 + 32'(c));
            ls_valid   = 1;
            ls_rd      = (c < 2) ? 5'(16 + c) : 5'd18;
            ls_data    = 32'hF0 + 32'(c);
            if (c >= 2) chk($sformatf("t6_ready_low_c%0d", c), ls_ready, 0);
            step();
        end
        expect_wr(16, 32'hF0);
        expect_wr(17, 32'hF1);
        pipe_valid = 0; ls_valid = 0;
`ifdef WB_STATS_EN
        chk("t6_stall_cnt", ls_stall_cnt, 4);
`endif
        repeat (5) step();
        chk("sb_drained", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of buffered long-latency results (legal range 1..8).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports pipe_valid (input, 1), pipe_rd (input, 5) and pipe_data (input, 32): the in-order pipeline writeback, which is never stalled.
REQ-005 SHALL have ports ls_valid (input, 1), ls_ready (output, 1), ls_rd (input, 5) and ls_data (input, 32): the long-latency result channel using a valid/ready handshake.
REQ-006 SHALL have ports write_enable (output, 1), rd (output, 5) and rd_din (output, 32): the register-file write port.
REQ-007 SHALL have port pending_mask, output, 32 bits: bit i set when a long-latency write to x_i is buffered or in flight.

Function
REQ-008 SHALL register write_enable, rd and rd_din, so a value is written to the register file on the clock edge after it appears on these outputs.
REQ-009 SHALL present a pipe write with 1-cycle latency: pipe_valid at edge N gives write_enable=1 during cycle N+1.
REQ-010 SHALL give the pipe priority; the FIFO head drains to the port only in cycles without a pipe write.
REQ-011 SHALL produce ls_ready = !fifo_full, a combinational function of state only and independent of ls_valid.
REQ-012 SHALL transfer a long-latency result only when ls_valid && ls_ready at the edge.
REQ-013 SHALL accept and drop any transfer with ls_rd==0 without enqueuing it.
REQ-014 SHALL never assert write_enable for rd==0, and a pipe write to x0 SHALL NOT block the FIFO from draining that cycle.
REQ-015 SHALL allow simultaneous enqueue and dequeue at any non-full occupancy, leaving the count unchanged.
REQ-016 SHALL drain the FIFO in strict arrival order, with wrap-around read and write pointers of width clog2(FIFO_DEPTH).
REQ-017 SHALL set a pending_mask bit at the ls handshake edge and clear it on the edge its write commits to the register file; duplicate rd entries are tracked with per-entry masks ORed together.
REQ-018 SHALL leave it to the upstream issue logic to ensure no pipe write targets a register whose pending_mask bit is set; the behaviour in that case is undefined and flagged by an assertion.
REQ-019 SHALL hold ls_ready low while the FIFO is full, with no accepted result lost.
REQ-020 SHALL, when write_enable is low, hold rd and rd_din at their last values.

Reset
REQ-021 SHALL, on reset assertion and regardless of clk, clear write_enable, rd, rd_din, pending_mask, the FIFO count and both pointers to 0.
REQ-022 SHALL discard buffered results on reset mid-operation, with ls_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-023 SHALL, with WB_STATS_EN defined, add output ls_stall_cnt (32 bits), which counts cycles with ls_valid && !ls_ready, saturates at 0xFFFFFFFF and resets to 0.
REQ-024 SHALL, without WB_STATS_EN, omit the ls_stall_cnt port and counter entirely.

Structure
REQ-025 SHALL take XLEN=32, REG_ADDR_W=5 and typedef wb_entry_t {rd, data} from shared package wb_pkg.
REQ-026 SHALL implement buffering in sub-module wb_fifo (parameterised depth, push/pop, full/empty, count).
REQ-027 SHALL keep the arbitration, output register and pending-mask logic in writeback_arbiter.

Verification
REQ-028 SHALL cover: pipe_valid, rd=5, data=0x1234 -> next cycle write_enable=1, rd=5, rd_din=0x1234.
REQ-029 SHALL cover: ls rd=7, data=0xAA and pipe rd=3 in the same cycle -> x3 written in cycle+1, x7 in cycle+2, pending_mask[7] set for two cycles then clear.
REQ-030 SHALL cover: pipe_valid every cycle while ls sends 3 results with depth 2 -> ls_ready=0 after 2 accepts; after the pipe idles, writes drain in order.
REQ-031 SHALL cover: ls_rd=0 accepted and pipe rd=0 -> write_enable never asserted, FIFO count stays 0.
REQ-032 SHALL cover: reset asserted mid-cycle with 2 entries buffered -> outputs immediately 0, pending_mask=0, ls_ready=1 after release, no stale write.
REQ-033 SHALL cover: with WB_STATS_EN, 4 full-FIFO cycles with ls_valid high -> ls_stall_cnt=4.
